univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register: successor to the fixed 8-bit
//   serial/parallel-load shifter. Supports hold, load, clear, logical
//   shift left/right, rotate left/right and arithmetic shift right.
//   Adds an autonomous burst engine that performs a programmed number of
//   shifts with busy/done handshake. Used as a serialiser/deserialiser and
//   barrel-free multi-bit shifter in datapaths.
// PARAMETERS
//   WIDTH      8   register width in bits (>=2)
//   CNT_W      4   width of burst_len; max burst = 2**CNT_W-1 shifts
//   RESET_VAL  0   value of Q after reset (WIDTH bits)
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   en           in   1       enables single-step op in IDLE
//   mode         in   3       op select (encoding below)
//   s_in         in   1       serial input bit
//   p_in         in   WIDTH   parallel load data
//   burst_start  in   1       start burst of burst_len shifts using mode
//   burst_len    in   CNT_W   number of shifts in burst
//   Q            out  WIDTH   register contents
//   s_out_msb    out  1       = Q[WIDTH-1] (combinational)
//   s_out_lsb    out  1       = Q[0] (combinational)
//   busy         out  1       burst in progress
//   done         out  1       one-cycle pulse: burst finished
//   err          out  1       one-cycle pulse: burst rejected (illegal mode)
// BEHAVIOUR
//   Reset (rst_n=0, async): Q=RESET_VAL, busy=0, done=0, err=0, FSM=IDLE,
//     count=0; takes effect immediately, also mid-burst.
//   mode: 000 HOLD; 001 LOAD Q<=p_in; 010 SHL Q<={Q[W-2:0],s_in};
//     011 SHR Q<={s_in,Q[W-1:1]}; 100 ROL Q<={Q[W-2:0],Q[W-1]};
//     101 ROR Q<={Q[0],Q[W-1:1]}; 110 ASR Q<={Q[W-1],Q[W-1:1]}; 111 CLEAR Q<=0.
//   FSM states IDLE, BURST, DONE.
//   IDLE: burst_start=1 has priority over en. If mode in 010..110: latch
//     mode and burst_len, no shift on this edge; go BURST (len>0) or DONE
//     (len=0). If mode is HOLD/LOAD/CLEAR: err=1 next cycle, Q unchanged,
//     stay IDLE. Else if en=1: apply mode once on this edge; en=0 holds Q.
//   BURST: busy=1. Each cycle apply latched op (s_in sampled live), count
//     decrements; mode, en, p_in, burst_start ignored. After last shift go
//     DONE. busy is high for exactly burst_len cycles.
//   DONE: done=1 for one cycle, busy=0, Q holds; return IDLE. burst_start
//     or en in DONE is ignored.
//   done/err are registered; never both high. No overflow: count is CNT_W
//     bits, loaded value is never exceeded.
// TESTING (WIDTH=8, CNT_W=4)
//   Reset: drop rst_n mid-burst -> Q=8'h00, busy=0, done=0 without clock edge.
//   LOAD 8'h55, then SHL s_in=1 x3 -> Q=8'hAB, 8'h57, 8'hAF; en=0 -> Q holds.
//   LOAD 8'h81, ROR -> 8'hC0; LOAD 8'h80, ASR x2 -> 8'hC0, 8'hE0; CLEAR -> 8'h00.
//   LOAD 8'h01, burst_start ROL len=3, toggle mode during burst -> busy 3 cycles,
//     Q=02,04,08, then done pulse one cycle, busy=0.
//   burst_start len=0 (SHR) -> busy never high, done next cycle, Q unchanged.
//   burst_start with mode=LOAD -> err pulse one cycle, Q unchanged, busy=0;
//     burst_start while busy -> ignored, burst length unaffected.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with single-step ops and an autonomous
// burst engine that performs a programmed number of shifts with busy/done/err.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] Q,
  output logic             s_out_msb,
  output logic             s_out_lsb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q,    op_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  function automatic logic [WIDTH-1:0] apply_op(input op_t              op,
                                                input logic [WIDTH-1:0] q,
                                                input logic             s,
                                                input logic [WIDTH-1:0] p);
    case (op)
      OP_HOLD:  return q;
      OP_LOAD:  return p;
      OP_SHL:   return {q[WIDTH-2:0], s};
      OP_SHR:   return {s, q[WIDTH-1:1]};
      OP_ROL:   return {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:   return {q[0], q[WIDTH-1:1]};
      OP_ASR:   return {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLEAR: return '0;
      default:  return q;
    endcase
  endfunction

  // Only the five shift/rotate ops make sense as a repeated burst.
  function automatic logic is_burst_op(input logic [2:0] m);
    return (m >= 3'b010) && (m <= 3'b110);
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    op_d    = op_q;
    q_d     = q_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (burst_start) begin
          if (is_burst_op(mode)) begin
            op_d    = op_t'(mode);
            count_d = burst_len;
            if (burst_len == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_BURST;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (en) begin
          q_d = apply_op(op_t'(mode), q_q, s_in, p_in);
        end
      end

      ST_BURST: begin
        q_d     = apply_op(op_q, q_q, s_in, p_in);
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      q_q     <= RESET_VAL;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      q_q     <= q_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Q         = q_q;
  assign s_out_msb = q_q[WIDTH-1];
  assign s_out_lsb = q_q[0];
  assign busy      = (state_q == ST_BURST);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic          s_in;
  logic [W-1:0]  p_in;
  logic          burst_start;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  Q;
  logic          s_out_msb, s_out_lsb, busy, done, err;

  int errors = 0;
  int checks = 0;

  // Reference model state: remaining shifts instead of an FSM encoding.
  logic [W-1:0] m_q;
  logic [2:0]   m_op;
  int           m_rem;
  bit           m_busy, m_done, m_err;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s_in(s_in), .p_in(p_in),
    .burst_start(burst_start), .burst_len(burst_len), .Q(Q),
    .s_out_msb(s_out_msb), .s_out_lsb(s_out_lsb),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] q,
                                          input logic s, input logic [W-1:0] p);
    logic [W-1:0] msb_s;
    msb_s = W'(s) << (W - 1);
    case (op)
      3'd0: return q;
      3'd1: return p;
      3'd2: return W'((q << 1) | W'(s));
      3'd3: return (q >> 1) | msb_s;
      3'd4: return W'((q << 1) | (q >> (W - 1)));
      3'd5: return W'((q >> 1) | (q << (W - 1)));
      3'd6: return W'($signed(q) >>> 1);
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_q = 8'h00; m_op = 3'd0; m_rem = 0;
    m_busy = 0; m_done = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    if (m_busy) begin
      m_q   = ref_op(m_op, m_q, s_in, p_in);
      m_rem = m_rem - 1;
      m_busy = (m_rem != 0);
      m_done = (m_rem == 0);
      m_err  = 0;
    end else if (m_done) begin
      m_done = 0;
    end else begin
      m_err = 0;
      if (burst_start) begin
        if (mode >= 3'd2 && mode <= 3'd6) begin
          m_op  = mode;
          m_rem = int'(burst_len);
          if (burst_len == 0) m_done = 1;
          else m_busy = 1;
        end else begin
          m_err = 1;
        end
      end else if (en) begin
        m_q = ref_op(mode, m_q, s_in, p_in);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // return 1 time unit after the rising edge so outputs can be sampled.
  task automatic cycle(input logic e, input logic [2:0] md, input logic s,
                       input logic [W-1:0] p, input logic bs, input logic [CW-1:0] len);
    @(negedge clk);
    en = e; mode = md; s_in = s; p_in = p; burst_start = bs; burst_len = len;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; mode = 0; s_in = 0; p_in = 0; burst_start = 0; burst_len = 0;
    model_reset();
    #12;
    checks++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q=%h busy=%b done=%b err=%b, required Q=00 busy=0 done=0 err=0",
               Q, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops();
    logic [W-1:0] exp_shl [3];
    exp_shl[0] = 8'hAB; exp_shl[1] = 8'h57; exp_shl[2] = 8'hAF;
    cycle(1, 3'd1, 0, 8'h55, 0, 0);
    checks++;
    if (Q !== 8'h55) begin errors++; $display("FAIL load_55: Q=%h required 55", Q); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3'd2, 1, 8'h00, 0, 0);
      checks++;
      if (Q !== exp_shl[i] || s_out_lsb !== 1'b1 || s_out_msb !== exp_shl[i][W-1]) begin
        errors++;
        $display("FAIL shl_step%0d: Q=%h lsb=%b msb=%b required Q=%h", i, Q, s_out_lsb, s_out_msb, exp_shl[i]);
      end
    end
    cycle(0, 3'd7, 0, 8'h00, 0, 0);
    checks++;
    if (Q !== 8'hAF) begin errors++; $display("FAIL en0_hold: Q=%h required AF", Q); end
    cycle(1, 3'd1, 0, 8'h81, 0, 0);
    cycle(1, 3'd5, 0, 8'h00, 0, 0);
    checks++;
    if (Q !== 8'hC0) begin errors++; $display("FAIL ror_81: Q=%h required C0", Q); end
    cycle(1, 3'd1, 0, 8'h80, 0, 0);
    cycle(1, 3'd6, 0, 8'h00, 0, 0);
    checks++;
    if (Q !== 8'hC0) begin errors++; $display("FAIL asr_1: Q=%h required C0", Q); end
    cycle(1, 3'd6, 1, 8'h00, 0, 0);
    checks++;
    if (Q !== 8'hE0) begin errors++; $display("FAIL asr_2: Q=%h required E0", Q); end
    cycle(1, 3'd3, 1, 8'h00, 0, 0);
    checks++;
    if (Q !== 8'hF0) begin errors++; $display("FAIL shr_sin1: Q=%h required F0", Q); end
    cycle(1, 3'd7, 0, 8'hFF, 0, 0);
    checks++;
    if (Q !== 8'h00) begin errors++; $display("FAIL clear: Q=%h required 00", Q); end
  endtask

  task automatic test_burst();
    logic [W-1:0] exp_q [4];
    logic         exp_busy [4];
    logic         exp_done [4];
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h04; exp_q[3] = 8'h08;
    exp_busy[0] = 1; exp_busy[1] = 1; exp_busy[2] = 1; exp_busy[3] = 0;
    exp_done[0] = 0; exp_done[1] = 0; exp_done[2] = 0; exp_done[3] = 1;
    cycle(1, 3'd1, 0, 8'h01, 0, 0);
    cycle(0, 3'd4, 0, 8'h00, 1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Q !== exp_q[i] || busy !== exp_busy[i] || done !== exp_done[i]) begin
        errors++;
        $display("FAIL burst_rol_step%0d: Q=%h busy=%b done=%b required Q=%h busy=%b done=%b",
                 i, Q, busy, done, exp_q[i], exp_busy[i], exp_done[i]);
      end
      // Mode toggling and a second burst_start while busy must be ignored.
      if (i < 3) cycle(1, 3'(i + 1), 1, 8'hFF, 1, 4'd15);
    end
    cycle(1, 3'd2, 1, 8'h00, 1, 4'd2);
    checks++;
    if (Q !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: Q=%h busy=%b done=%b required Q=08 busy=0 done=0", Q, busy, done);
    end
  endtask

  task automatic test_burst_zero_and_illegal();
    cycle(1, 3'd1, 0, 8'hA5, 0, 0);
    cycle(0, 3'd3, 1, 8'h00, 1, 4'd0);
    checks++;
    if (Q !== 8'hA5 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL burst_len0: Q=%h busy=%b done=%b required Q=A5 busy=0 done=1", Q, busy, done);
    end
    cycle(0, 3'd0, 0, 8'h00, 0, 0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_pulse_end: busy=%b done=%b required 0 0", busy, done);
    end
    cycle(1, 3'd1, 0, 8'hFF, 1, 4'd5);
    checks++;
    if (Q !== 8'hA5 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL burst_illegal: Q=%h err=%b busy=%b done=%b required Q=A5 err=1 busy=0 done=0",
               Q, err, busy, done);
    end
    cycle(0, 3'd0, 0, 8'h00, 0, 0);
    checks++;
    if (err !== 1'b0 || Q !== 8'hA5) begin
      errors++; $display("FAIL err_pulse_end: err=%b Q=%h required err=0 Q=A5", err, Q);
    end
  endtask

  task automatic test_reset_mid_burst();
    cycle(1, 3'd1, 0, 8'h3C, 0, 0);
    cycle(0, 3'd2, 1, 8'h00, 1, 4'd9);
    cycle(0, 3'd0, 1, 8'h00, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: Q=%h busy=%b done=%b err=%b required 00 0 0 0", Q, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic       bs;
    logic [2:0] md;
    for (int n = 0; n < 1500; n++) begin
      md = 3'($urandom_range(0, 7));
      bs = ($urandom_range(0, 7) == 0);
      cycle(1'($urandom), md, 1'($urandom), W'($urandom), bs, CW'($urandom_range(0, 15)));
      checks++;
      if (Q !== m_q || busy !== m_busy || done !== m_done || err !== m_err ||
          s_out_msb !== m_q[W-1] || s_out_lsb !== m_q[0]) begin
        errors++;
        $display("FAIL random_cycle%0d: Q=%h busy=%b done=%b err=%b msb=%b lsb=%b required Q=%h busy=%b done=%b err=%b",
                 n, Q, busy, done, err, s_out_msb, s_out_lsb, m_q, m_busy, m_done, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_burst();
    test_burst_zero_and_illegal();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
